// File: rtl/sdim_output_packer.sv
//-----------------------------------------------------------------------------
// sdim_output_packer
//
// Collects ELEM_WIDTH-bit elements, arriving one per beat on s_axis_input0,
// and emits them OUTPUT0_SDIM elements per beat on m_axis_output0. Lane 0
// holds the first element received. A packet that ends before the beat is
// full (input tlast) is closed early. The unused upper lanes are zeroed and
// their tkeep bits are cleared. Elements are never packed across a packet
// boundary.
//
// Parameters
//   ELEM_WIDTH    bits per element (>= 1)
//   OUTPUT0_SDIM  elements per output beat (>= 1); 1 gives a registered
//                 pass-through
//
// Ports
//   ap_clk                 sole clock, rising edge
//   ap_rst_n               asynchronous active-low reset
//   s_axis_input0_*        scalar element stream (tdata/tvalid/tready/tlast)
//   m_axis_output0_tdata   packed beat, lane k at [k*ELEM_WIDTH +: ELEM_WIDTH]
//   m_axis_output0_tkeep   one bit per lane, 1 = lane holds real data
//   m_axis_output0_tvalid  beat valid (registered, independent of tready)
//   m_axis_output0_tready  downstream ready
//   m_axis_output0_tlast   beat closes a packet
//-----------------------------------------------------------------------------
`timescale 1ns / 1ps

module sdim_output_packer #(
    parameter int ELEM_WIDTH   = 8,
    parameter int OUTPUT0_SDIM = 2
) (
    input  logic                               ap_clk,
    input  logic                               ap_rst_n,

    input  logic [ELEM_WIDTH-1:0]              s_axis_input0_tdata,
    input  logic                               s_axis_input0_tvalid,
    output logic                               s_axis_input0_tready,
    input  logic                               s_axis_input0_tlast,

    output logic [ELEM_WIDTH*OUTPUT0_SDIM-1:0] m_axis_output0_tdata,
    output logic [OUTPUT0_SDIM-1:0]            m_axis_output0_tkeep,
    output logic                               m_axis_output0_tvalid,
    input  logic                               m_axis_output0_tready,
    output logic                               m_axis_output0_tlast
);

    localparam int BEAT_W = ELEM_WIDTH * OUTPUT0_SDIM;
    localparam int FILL_W = (OUTPUT0_SDIM > 1) ? $clog2(OUTPUT0_SDIM) : 1;
    localparam logic [FILL_W-1:0] LAST_LANE = FILL_W'(OUTPUT0_SDIM - 1);

    generate
        if (ELEM_WIDTH < 1 || OUTPUT0_SDIM < 1) begin : g_bad_param
            $error("sdim_output_packer: ELEM_WIDTH and OUTPUT0_SDIM must be >= 1");
        end
    endgenerate

    // Fill position of the beat under construction
    logic [FILL_W-1:0]     fill_q, fill_d;

    // Lanes collected so far for the beat under construction
    logic [ELEM_WIDTH-1:0] acc_q [OUTPUT0_SDIM];

    // Output register
    logic                  out_valid_q, out_valid_d;
    logic [BEAT_W-1:0]     out_data_q,  out_data_d;
    logic [OUTPUT0_SDIM-1:0] out_keep_q, out_keep_d;
    logic                  out_last_q,  out_last_d;

    logic                  out_free;
    logic                  in_fire;
    logic                  beat_done;
    logic [BEAT_W-1:0]     beat_data;
    logic [OUTPUT0_SDIM-1:0] beat_keep;

    // The output slot is free when empty or being drained this cycle, so
    // input tready combinationally follows output tready.
    assign out_free             = !out_valid_q || m_axis_output0_tready;
    assign s_axis_input0_tready = out_free;
    assign in_fire              = s_axis_input0_tvalid && out_free;
    assign beat_done            = in_fire && ((fill_q == LAST_LANE) || s_axis_input0_tlast);

    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path can
        // leave one unassigned and infer a latch.
        beat_data   = '0;
        beat_keep   = '0;
        fill_d      = fill_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_keep_d  = out_keep_q;
        out_last_d  = out_last_q;

        // Lanes below fill come from the accumulator, lane fill is the
        // arriving element, lanes above stay zero with keep cleared.
        for (int k = 0; k < OUTPUT0_SDIM; k++) begin
            if (k < int'(fill_q)) begin
                beat_data[k*ELEM_WIDTH +: ELEM_WIDTH] = acc_q[k];
                beat_keep[k]                          = 1'b1;
            end else if (k == int'(fill_q)) begin
                beat_data[k*ELEM_WIDTH +: ELEM_WIDTH] = s_axis_input0_tdata;
                beat_keep[k]                          = 1'b1;
            end
        end

        if (in_fire) begin
            fill_d = beat_done ? '0 : fill_q + FILL_W'(1);
        end

        // A load wins over a drain: the new beat replaces the old one and
        // tvalid stays high with no bubble.
        if (beat_done) begin
            out_valid_d = 1'b1;
            out_data_d  = beat_data;
            out_keep_d  = beat_keep;
            out_last_d  = s_axis_input0_tlast;
        end else if (m_axis_output0_tready) begin
            out_valid_d = 1'b0;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge value of every other flop.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            fill_q      <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_keep_q  <= '0;
            out_last_q  <= 1'b0;
        end else begin
            fill_q      <= fill_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_keep_q  <= out_keep_d;
            out_last_q  <= out_last_d;
        end
    end

    // NOTE: the accumulator has no reset. A lane is only read after it has
    // been written in the current packet, and resetting fill alone discards
    // a partial packet.
    always_ff @(posedge ap_clk) begin
        if (in_fire && !beat_done) begin
            acc_q[fill_q] <= s_axis_input0_tdata;
        end
    end

    assign m_axis_output0_tvalid = out_valid_q;
    assign m_axis_output0_tdata  = out_data_q;
    assign m_axis_output0_tkeep  = out_keep_q;
    assign m_axis_output0_tlast  = out_last_q;

endmodule

// File: tb/tb_sdim_output_packer.sv
`timescale 1ns / 1ps

module tb_sdim_output_packer;

    typedef struct {
        logic [31:0] data;
        logic [3:0]  keep;
        logic        last;
    } beat_t;

    logic clk = 1'b0;
    logic ap_rst_n = 1'b0;
    always #5 clk = ~clk;

    int tests_run    = 0;
    int tests_failed = 0;

    beat_t q_a[$];
    beat_t q_b[$];
    beat_t q_c[$];

    // Instance A: OUTPUT0_SDIM = 2
    logic [7:0]  a_s_tdata = '0;
    logic        a_s_tvalid = 1'b0, a_s_tlast = 1'b0, a_s_tready;
    logic [15:0] a_tdata;
    logic [1:0]  a_tkeep;
    logic        a_tvalid, a_tlast, a_m_tready = 1'b1;

    // Instance B: OUTPUT0_SDIM = 4
    logic [7:0]  b_s_tdata = '0;
    logic        b_s_tvalid = 1'b0, b_s_tlast = 1'b0, b_s_tready;
    logic [31:0] b_tdata;
    logic [3:0]  b_tkeep;
    logic        b_tvalid, b_tlast, b_m_tready = 1'b1;

    // Instance C: OUTPUT0_SDIM = 1
    logic [7:0]  c_s_tdata = '0;
    logic        c_s_tvalid = 1'b0, c_s_tlast = 1'b0, c_s_tready;
    logic [7:0]  c_tdata;
    logic [0:0]  c_tkeep;
    logic        c_tvalid, c_tlast, c_m_tready = 1'b1;

    sdim_output_packer #(.ELEM_WIDTH(8), .OUTPUT0_SDIM(2)) u_a (
        .ap_clk(clk), .ap_rst_n(ap_rst_n),
        .s_axis_input0_tdata(a_s_tdata), .s_axis_input0_tvalid(a_s_tvalid),
        .s_axis_input0_tready(a_s_tready), .s_axis_input0_tlast(a_s_tlast),
        .m_axis_output0_tdata(a_tdata), .m_axis_output0_tkeep(a_tkeep),
        .m_axis_output0_tvalid(a_tvalid), .m_axis_output0_tready(a_m_tready),
        .m_axis_output0_tlast(a_tlast)
    );

    sdim_output_packer #(.ELEM_WIDTH(8), .OUTPUT0_SDIM(4)) u_b (
        .ap_clk(clk), .ap_rst_n(ap_rst_n),
        .s_axis_input0_tdata(b_s_tdata), .s_axis_input0_tvalid(b_s_tvalid),
        .s_axis_input0_tready(b_s_tready), .s_axis_input0_tlast(b_s_tlast),
        .m_axis_output0_tdata(b_tdata), .m_axis_output0_tkeep(b_tkeep),
        .m_axis_output0_tvalid(b_tvalid), .m_axis_output0_tready(b_m_tready),
        .m_axis_output0_tlast(b_tlast)
    );

    sdim_output_packer #(.ELEM_WIDTH(8), .OUTPUT0_SDIM(1)) u_c (
        .ap_clk(clk), .ap_rst_n(ap_rst_n),
        .s_axis_input0_tdata(c_s_tdata), .s_axis_input0_tvalid(c_s_tvalid),
        .s_axis_input0_tready(c_s_tready), .s_axis_input0_tlast(c_s_tlast),
        .m_axis_output0_tdata(c_tdata), .m_axis_output0_tkeep(c_tkeep),
        .m_axis_output0_tvalid(c_tvalid), .m_axis_output0_tready(c_m_tready),
        .m_axis_output0_tlast(c_tlast)
    );

    // Scoreboard monitors: sample between edges, pop on each output handshake.
    always @(negedge clk) begin : mon_a
        beat_t e;
        #2;
        if (a_tvalid && a_m_tready) begin
            tests_run++;
            if (q_a.size() == 0) begin
                tests_failed++;
                $display("FAIL mon_a_unexpected: got data=%h keep=%b last=%b, expected no beat", a_tdata, a_tkeep, a_tlast);
            end else begin
                e = q_a.pop_front();
                if ({16'h0, a_tdata} !== e.data || {2'b0, a_tkeep} !== e.keep || a_tlast !== e.last) begin
                    tests_failed++;
                    $display("FAIL mon_a_beat: got data=%h keep=%b last=%b, expected data=%h keep=%b last=%b",
                             a_tdata, a_tkeep, a_tlast, e.data, e.keep, e.last);
                end
            end
        end
    end

    always @(negedge clk) begin : mon_b
        beat_t e;
        #2;
        if (b_tvalid && b_m_tready) begin
            tests_run++;
            if (q_b.size() == 0) begin
                tests_failed++;
                $display("FAIL mon_b_unexpected: got data=%h keep=%b last=%b, expected no beat", b_tdata, b_tkeep, b_tlast);
            end else begin
                e = q_b.pop_front();
                if (b_tdata !== e.data || b_tkeep !== e.keep || b_tlast !== e.last) begin
                    tests_failed++;
                    $display("FAIL mon_b_beat: got data=%h keep=%b last=%b, expected data=%h keep=%b last=%b",
                             b_tdata, b_tkeep, b_tlast, e.data, e.keep, e.last);
                end
            end
        end
    end

    always @(negedge clk) begin : mon_c
        beat_t e;
        #2;
        if (c_tvalid && c_m_tready) begin
            tests_run++;
            if (q_c.size() == 0) begin
                tests_failed++;
                $display("FAIL mon_c_unexpected: got data=%h keep=%b last=%b, expected no beat", c_tdata, c_tkeep, c_tlast);
            end else begin
                e = q_c.pop_front();
                if ({24'h0, c_tdata} !== e.data || {3'b0, c_tkeep} !== e.keep || c_tlast !== e.last) begin
                    tests_failed++;
                    $display("FAIL mon_c_beat: got data=%h keep=%b last=%b, expected data=%h keep=%b last=%b",
                             c_tdata, c_tkeep, c_tlast, e.data, e.keep, e.last);
                end
            end
        end
    end

    // Send tasks: called at a falling edge, return at the falling edge after
    // the element was accepted; tvalid is left high for back-to-back use.
    task automatic send_a(input logic [7:0] d, input logic l);
        int n = 0;
        a_s_tdata = d; a_s_tlast = l; a_s_tvalid = 1'b1;
        #1;
        while (!a_s_tready && n < 50) begin @(negedge clk); #1; n++; end
        if (!a_s_tready) begin
            tests_run++; tests_failed++;
            $display("FAIL send_a_timeout: tready=0 after %0d cycles, expected 1", n);
        end
        @(negedge clk);
    endtask

    task automatic send_b(input logic [7:0] d, input logic l);
        int n = 0;
        b_s_tdata = d; b_s_tlast = l; b_s_tvalid = 1'b1;
        #1;
        while (!b_s_tready && n < 50) begin @(negedge clk); #1; n++; end
        if (!b_s_tready) begin
            tests_run++; tests_failed++;
            $display("FAIL send_b_timeout: tready=0 after %0d cycles, expected 1", n);
        end
        @(negedge clk);
    endtask

    task automatic send_c(input logic [7:0] d, input logic l);
        int n = 0;
        c_s_tdata = d; c_s_tlast = l; c_s_tvalid = 1'b1;
        #1;
        while (!c_s_tready && n < 50) begin @(negedge clk); #1; n++; end
        if (!c_s_tready) begin
            tests_run++; tests_failed++;
            $display("FAIL send_c_timeout: tready=0 after %0d cycles, expected 1", n);
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        ap_rst_n = 1'b0;
        repeat (2) @(negedge clk);
        tests_run++;
        if ({a_tvalid, a_tdata, a_tkeep, a_tlast} !== 20'h0) begin
            tests_failed++;
            $display("FAIL reset_a_outputs: got valid=%b data=%h keep=%b last=%b, expected all 0", a_tvalid, a_tdata, a_tkeep, a_tlast);
        end
        tests_run++;
        if ({b_tvalid, b_tdata, b_tkeep, b_tlast} !== 38'h0) begin
            tests_failed++;
            $display("FAIL reset_b_outputs: got valid=%b data=%h keep=%b last=%b, expected all 0", b_tvalid, b_tdata, b_tkeep, b_tlast);
        end
        tests_run++;
        if ({c_tvalid, c_tdata, c_tkeep, c_tlast} !== 11'h0) begin
            tests_failed++;
            $display("FAIL reset_c_outputs: got valid=%b data=%h keep=%b last=%b, expected all 0", c_tvalid, c_tdata, c_tkeep, c_tlast);
        end
        tests_run++;
        if ({a_s_tready, b_s_tready, c_s_tready} !== 3'b111) begin
            tests_failed++;
            $display("FAIL reset_s_tready: got %b, expected 111", {a_s_tready, b_s_tready, c_s_tready});
        end
        ap_rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_full_beats();
        a_m_tready = 1'b1;
        q_a.push_back('{data: 32'h2211, keep: 4'b0011, last: 1'b0});
        q_a.push_back('{data: 32'h4433, keep: 4'b0011, last: 1'b1});
        send_a(8'h11, 1'b0);
        tests_run++;
        if (a_tvalid !== 1'b0) begin
            tests_failed++;
            $display("FAIL full_half_beat_valid: got %b, expected 0", a_tvalid);
        end
        send_a(8'h22, 1'b0);
        tests_run++;
        if (a_tvalid !== 1'b1 || a_tdata !== 16'h2211) begin
            tests_failed++;
            $display("FAIL full_beat0_latency: got valid=%b data=%h, expected valid=1 data=2211", a_tvalid, a_tdata);
        end
        send_a(8'h33, 1'b0);
        send_a(8'h44, 1'b1);
        a_s_tvalid = 1'b0; a_s_tlast = 1'b0;
        tests_run++;
        if (a_tvalid !== 1'b1 || a_tdata !== 16'h4433 || a_tlast !== 1'b1) begin
            tests_failed++;
            $display("FAIL full_beat1_latency: got valid=%b data=%h last=%b, expected valid=1 data=4433 last=1", a_tvalid, a_tdata, a_tlast);
        end
        repeat (3) @(negedge clk);
        tests_run++;
        if (q_a.size() != 0) begin
            tests_failed++;
            $display("FAIL full_drain: got %0d beats outstanding, expected 0", q_a.size());
        end
    endtask

    task automatic test_backpressure();
        a_m_tready = 1'b1;
        q_a.push_back('{data: 32'h2211, keep: 4'b0011, last: 1'b0});
        q_a.push_back('{data: 32'h4433, keep: 4'b0011, last: 1'b1});
        send_a(8'h11, 1'b0);
        send_a(8'h22, 1'b0);
        a_m_tready = 1'b0;
        a_s_tdata = 8'h33; a_s_tlast = 1'b0; a_s_tvalid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            tests_run++;
            if (a_tvalid !== 1'b1 || a_tdata !== 16'h2211 || a_tkeep !== 2'b11 || a_tlast !== 1'b0 || a_s_tready !== 1'b0) begin
                tests_failed++;
                $display("FAIL stall_cycle%0d: got valid=%b data=%h keep=%b last=%b s_tready=%b, expected 1 2211 11 0 0",
                         i, a_tvalid, a_tdata, a_tkeep, a_tlast, a_s_tready);
            end
            @(negedge clk);
        end
        a_m_tready = 1'b1;
        send_a(8'h33, 1'b0);
        send_a(8'h44, 1'b1);
        a_s_tvalid = 1'b0; a_s_tlast = 1'b0;
        repeat (3) @(negedge clk);
        tests_run++;
        if (q_a.size() != 0) begin
            tests_failed++;
            $display("FAIL stall_drain: got %0d beats outstanding, expected 0", q_a.size());
        end
    endtask

    task automatic test_early_tlast();
        b_m_tready = 1'b1;
        q_b.push_back('{data: 32'h00A3A2A1, keep: 4'b0111, last: 1'b1});
        q_b.push_back('{data: 32'hB4B3B2B1, keep: 4'b1111, last: 1'b1});
        send_b(8'hA1, 1'b0);
        send_b(8'hA2, 1'b0);
        send_b(8'hA3, 1'b1);
        tests_run++;
        if (b_tvalid !== 1'b1 || b_tkeep !== 4'b0111 || b_tdata !== 32'h00A3A2A1) begin
            tests_failed++;
            $display("FAIL early_short_beat: got valid=%b data=%h keep=%b, expected 1 00a3a2a1 0111", b_tvalid, b_tdata, b_tkeep);
        end
        send_b(8'hB1, 1'b0);
        send_b(8'hB2, 1'b0);
        send_b(8'hB3, 1'b0);
        send_b(8'hB4, 1'b1);
        b_s_tvalid = 1'b0; b_s_tlast = 1'b0;
        repeat (3) @(negedge clk);
        tests_run++;
        if (q_b.size() != 0) begin
            tests_failed++;
            $display("FAIL early_drain: got %0d beats outstanding, expected 0", q_b.size());
        end
    endtask

    task automatic test_single_lane();
        time t0;
        c_m_tready = 1'b1;
        q_c.push_back('{data: 32'h5A, keep: 4'b0001, last: 1'b1});
        send_c(8'h5A, 1'b1);
        c_s_tvalid = 1'b0;
        tests_run++;
        if (c_tvalid !== 1'b1 || c_tdata !== 8'h5A || c_tkeep !== 1'b1 || c_tlast !== 1'b1) begin
            tests_failed++;
            $display("FAIL single_passthru: got valid=%b data=%h keep=%b last=%b, expected 1 5a 1 1", c_tvalid, c_tdata, c_tkeep, c_tlast);
        end
        @(negedge clk);
        t0 = $time;
        for (int i = 0; i < 8; i++) begin
            q_c.push_back('{data: 32'(8'h60 + i), keep: 4'b0001, last: (i == 7)});
            send_c(8'(8'h60 + i), i == 7);
            tests_run++;
            if (c_tvalid !== 1'b1 || c_tdata !== 8'(8'h60 + i)) begin
                tests_failed++;
                $display("FAIL single_stream%0d: got valid=%b data=%h, expected 1 %h", i, c_tvalid, c_tdata, 8'(8'h60 + i));
            end
        end
        c_s_tvalid = 1'b0; c_s_tlast = 1'b0;
        tests_run++;
        if ($time - t0 != 80) begin
            tests_failed++;
            $display("FAIL single_rate: got %0t ns for 8 elements, expected 80", $time - t0);
        end
        repeat (3) @(negedge clk);
        tests_run++;
        if (q_c.size() != 0) begin
            tests_failed++;
            $display("FAIL single_drain: got %0d beats outstanding, expected 0", q_c.size());
        end
    endtask

    task automatic test_reset_mid_packet();
        b_m_tready = 1'b1;
        send_b(8'h01, 1'b0);
        send_b(8'h02, 1'b0);
        b_s_tvalid = 1'b0;
        #3 ap_rst_n = 1'b0;
        #1;
        tests_run++;
        if ({b_tvalid, b_tdata, b_tkeep, b_tlast} !== 38'h0 || {a_tvalid, a_tdata} !== 17'h0 || {c_tvalid, c_tdata} !== 9'h0) begin
            tests_failed++;
            $display("FAIL midrst_during: got b valid=%b data=%h keep=%b last=%b, expected all 0", b_tvalid, b_tdata, b_tkeep, b_tlast);
        end
        #3 ap_rst_n = 1'b1;
        @(negedge clk);
        tests_run++;
        if ({b_tvalid, b_tdata, b_tkeep, b_tlast} !== 38'h0) begin
            tests_failed++;
            $display("FAIL midrst_after: got b valid=%b data=%h keep=%b last=%b, expected all 0", b_tvalid, b_tdata, b_tkeep, b_tlast);
        end
        q_b.push_back('{data: 32'h13121110, keep: 4'b1111, last: 1'b0});
        send_b(8'h10, 1'b0);
        send_b(8'h11, 1'b0);
        send_b(8'h12, 1'b0);
        send_b(8'h13, 1'b0);
        b_s_tvalid = 1'b0;
        tests_run++;
        if (b_tvalid !== 1'b1 || b_tdata !== 32'h13121110 || b_tkeep !== 4'b1111) begin
            tests_failed++;
            $display("FAIL midrst_beat: got valid=%b data=%h keep=%b, expected 1 13121110 1111", b_tvalid, b_tdata, b_tkeep);
        end
        repeat (3) @(negedge clk);
        tests_run++;
        if (q_b.size() != 0) begin
            tests_failed++;
            $display("FAIL midrst_drain: got %0d beats outstanding, expected 0", q_b.size());
        end
    endtask

    task automatic test_back_to_back();
        a_m_tready = 1'b1;
        // Continuous full packets: one beat every 2 cycles, drained in between.
        for (int i = 0; i < 8; i++) begin
            if (i % 2 == 1)
                q_a.push_back('{data: 32'(((8'h80 + i) << 8) | (8'h80 + i - 1)), keep: 4'b0011, last: (i == 7)});
            send_a(8'(8'h80 + i), i == 7);
            tests_run++;
            if (a_tvalid !== ((i % 2) == 1)) begin
                tests_failed++;
                $display("FAIL b2b_valid%0d: got %b, expected %b", i, a_tvalid, (i % 2) == 1);
            end
        end
        // Single-element packets: a load every cycle while draining, no bubble.
        for (int i = 0; i < 4; i++) begin
            q_a.push_back('{data: 32'(8'hC0 + i), keep: 4'b0001, last: 1'b1});
            send_a(8'(8'hC0 + i), 1'b1);
            tests_run++;
            if (a_tvalid !== 1'b1 || a_tdata !== 16'(8'hC0 + i) || a_tkeep !== 2'b01) begin
                tests_failed++;
                $display("FAIL b2b_drain_load%0d: got valid=%b data=%h keep=%b, expected 1 %h 01",
                         i, a_tvalid, a_tdata, a_tkeep, 16'(8'hC0 + i));
            end
        end
        a_s_tvalid = 1'b0; a_s_tlast = 1'b0;
        repeat (3) @(negedge clk);
        tests_run++;
        if (q_a.size() != 0) begin
            tests_failed++;
            $display("FAIL b2b_drain: got %0d beats outstanding, expected 0", q_a.size());
        end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_full_beats();
        test_backpressure();
        test_early_tlast();
        test_single_lane();
        test_reset_mid_packet();
        test_back_to_back();
        repeat (2) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
